// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                boot loader (FSM state and error code encodings).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    // Default instruction memory size in bytes
    localparam int IMEM_BYTES = 1241;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    // Reason reported on err_code when a load aborts
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction memory programmer. Receives a framed
//                byte stream (LEN_LO, LEN_HI, payload, XOR checksum) and
//                writes the payload to consecutive byte addresses, holding
//                the CPU in stall until a load completes with a good checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES      = IMEM_BYTES,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] byte_count
);

    // Idle-counter value at which the next idle cycle triggers a timeout
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_base     = 32'(BASE_ADDR);
    localparam logic [31:0] c_mem      = 32'(MEM_BYTES);

    loader_state_t r_state;
    err_code_t     r_err_code;
    logic          r_rx_ready;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [7:0]    r_mem_wdata;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_err;
    logic [15:0]   r_byte_count;
    logic [15:0]   r_len;
    logic [7:0]    r_len_lo;
    logic [7:0]    r_chk;
    logic [15:0]   r_tmo;

    logic          w_accept;
    logic          w_timed;
    logic          w_timeout;
    logic [15:0]   w_len_n;
    logic          w_len_too_big;
    logic          w_last_data;

    assign w_accept      = rx_valid && r_rx_ready;
    assign w_timed       = (r_state == LEN_HI) || (r_state == DATA) || (r_state == CHECK);
    // An accepted byte in the same cycle always beats the timeout
    assign w_timeout     = w_timed && !w_accept && (r_tmo == c_tmo_last);
    assign w_len_n       = {rx_data, r_len_lo};
    // Checking the end address up front keeps every write inside the memory
    assign w_len_too_big = (c_base + {16'd0, w_len_n}) > c_mem;
    assign w_last_data   = (r_byte_count + 16'd1) == r_len;

    // Loader FSM with registered handshake, write port and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_err_code   <= ERR_NONE;
            r_rx_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 8'd0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_byte_count <= 16'd0;
            r_len        <= 16'd0;
            r_len_lo     <= 8'd0;
            r_chk        <= 8'd0;
            r_tmo        <= 16'd0;
        end else begin
            // Write strobe is a single-cycle pulse
            r_mem_we <= 1'b0;

            // Idle counter: cleared by acceptance or on firing, else counts
            if (w_timed) begin
                if (w_accept || w_timeout) begin
                    r_tmo <= 16'd0;
                end else begin
                    r_tmo <= r_tmo + 16'd1;
                end
            end

            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_state      <= LEN_LO;
                        r_rx_ready   <= 1'b1;
                        r_cpu_hold   <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_err_code   <= ERR_NONE;
                        r_byte_count <= 16'd0;
                        r_chk        <= 8'd0;
                        r_tmo        <= 16'd0;
                    end
                end

                LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= rx_data;
                        r_state  <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_n;
                        if (w_len_too_big) begin
                            r_state    <= ERR;
                            r_rx_ready <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_LEN;
                        end else if (w_len_n == 16'd0) begin
                            r_state <= CHECK;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (w_accept) begin
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= c_base + {16'd0, r_byte_count};
                        r_mem_wdata  <= rx_data;
                        r_byte_count <= r_byte_count + 16'd1;
                        r_chk        <= r_chk ^ rx_data;
                        if (w_last_data) begin
                            r_state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        if (rx_data == r_chk) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state    <= ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CHK;
                        end
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_rx_ready <= 1'b0;
                end
            endcase

            // Timeout overrides the per-state branch; any write already
            // registered in the previous cycle still completes
            if (w_timeout) begin
                r_state    <= ERR;
                r_rx_ready <= 1'b0;
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign byte_count = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected memory writes
//                are queued as bytes are driven and matched as mem_we fires.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] byte_count;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    wr_t exp_q[$];

    imem_loader #(
        .MEM_BYTES      (1241),
        .BASE_ADDR      (0),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'd0, mem_we}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"},   {31'd0, rx_ready}, 32'd0);
        check({tag, "_mem_we"},     {31'd0, mem_we},   32'd0);
        check({tag, "_mem_addr"},   mem_addr,          32'd0);
        check({tag, "_mem_wdata"},  {24'd0, mem_wdata}, 32'd0);
        check({tag, "_cpu_hold"},   {31'd0, cpu_hold}, 32'd1);
        check({tag, "_done"},       {31'd0, done},     32'd0);
        check({tag, "_err"},        {31'd0, err},      32'd0);
        check({tag, "_err_code"},   {30'd0, err_code}, 32'd0);
        check({tag, "_byte_count"}, {16'd0, byte_count}, 32'd0);
    endtask

    // All stimulus tasks start and end on a falling edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit is_data, input logic [31:0] addr);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            check("ready_wait", {31'd0, rx_ready}, 32'd1);
        end else begin
            if (is_data) exp_q.push_back('{addr, b, cyc + 1});
            @(negedge clk);
        end
    endtask

    // Bytes at indices 2 .. 2+n_data-1 are payload and produce writes
    task automatic send_frame(input byte_q_t fr, input int n_data);
        for (int i = 0; i < fr.size(); i++) begin
            send(fr[i], (i >= 2) && (i < 2 + n_data), 32'(i - 2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t fr;
        logic [7:0] x;

        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Good 4-byte frame
        pulse_start();
        check("t1_ready_after_start", {31'd0, rx_ready}, 32'd1);
        fr = '{8'h04, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00, 8'hA5};
        send_frame(fr, 4);
        check("t1_done",       {31'd0, done},       32'd1);
        check("t1_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        check("t1_err",        {31'd0, err},        32'd0);
        check("t1_byte_count", {16'd0, byte_count}, 32'd4);
        check("t1_rx_ready",   {31'd0, rx_ready},   32'd0);
        idle(2);
        check("t1_pending", exp_q.size(), 32'd0);

        // Same frame, bad checksum
        pulse_start();
        check("t2_hold_on_start", {31'd0, cpu_hold},   32'd1);
        check("t2_done_cleared",  {31'd0, done},       32'd0);
        check("t2_count_cleared", {16'd0, byte_count}, 32'd0);
        fr = '{8'h04, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00, 8'hA4};
        send_frame(fr, 4);
        check("t2_err",      {31'd0, err},      32'd1);
        check("t2_err_code", {30'd0, err_code}, 32'd2);
        check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("t2_done",     {31'd0, done},     32'd0);
        idle(2);
        check("t2_pending", exp_q.size(), 32'd0);

        // Length one past the memory size
        pulse_start();
        check("t3_err_cleared",  {31'd0, err},      32'd0);
        check("t3_code_cleared", {30'd0, err_code}, 32'd0);
        fr = '{8'hDA, 8'h04};
        send_frame(fr, 0);
        check("t3_err",      {31'd0, err},      32'd1);
        check("t3_err_code", {30'd0, err_code}, 32'd1);
        check("t3_rx_ready", {31'd0, rx_ready}, 32'd0);
        idle(3);
        check("t3_count", {16'd0, byte_count}, 32'd0);

        // Length exactly the memory size: last address 1240
        pulse_start();
        fr = {};
        fr.push_back(8'hD9);
        fr.push_back(8'h04);
        x = 8'h00;
        for (int i = 0; i < 1241; i++) begin
            fr.push_back(8'(i) ^ 8'h5A);
            x = x ^ (8'(i) ^ 8'h5A);
        end
        fr.push_back(x);
        send_frame(fr, 1241);
        check("t4_done",       {31'd0, done},       32'd1);
        check("t4_byte_count", {16'd0, byte_count}, 32'd1241);
        check("t4_last_addr",  mem_addr,            32'd1240);
        idle(2);
        check("t4_pending", exp_q.size(), 32'd0);

        // Timeout after one payload byte
        pulse_start();
        fr = '{8'h04, 8'h00, 8'hB7};
        send_frame(fr, 1);
        idle(9);
        check("t5_no_err_at_9", {31'd0, err}, 32'd0);
        idle(1);
        check("t5_err",        {31'd0, err},        32'd1);
        check("t5_err_code",   {30'd0, err_code},   32'd3);
        check("t5_byte_count", {16'd0, byte_count}, 32'd1);
        check("t5_rx_ready",   {31'd0, rx_ready},   32'd0);
        check("t5_pending",    exp_q.size(),        32'd0);

        // Zero-length frame, then a 2-byte frame
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        check("t6_done",       {31'd0, done},       32'd1);
        check("t6_byte_count", {16'd0, byte_count}, 32'd0);
        idle(2);
        pulse_start();
        check("t6_hold_again", {31'd0, cpu_hold}, 32'd1);
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h13};
        send_frame(fr, 2);
        check("t6_done2",       {31'd0, done},       32'd1);
        check("t6_byte_count2", {16'd0, byte_count}, 32'd2);
        check("t6_cpu_hold2",   {31'd0, cpu_hold},   32'd0);
        idle(2);
        check("t6_pending", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of the payload
        pulse_start();
        fr = '{8'h04, 8'h00, 8'hAA, 8'h55};
        send_frame(fr, 2);
        check("t7_mid_count", {16'd0, byte_count}, 32'd2);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h04;
        repeat (5) @(negedge clk);
        check("t7_no_ready", {31'd0, rx_ready},   32'd0);
        check("t7_count",    {16'd0, byte_count}, 32'd0);
        check("t7_hold",     {31'd0, cpu_hold},   32'd1);
        idle(1);
        pulse_start();
        fr = '{8'h01, 8'h00, 8'h77, 8'h77};
        send_frame(fr, 1);
        check("t7_done", {31'd0, done}, 32'd1);
        idle(2);
        check("t7_pending", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
